add_accum: RTL and testbench
============================

Name: add_accum

Overview:
- Sequential stage directly downstream of the 4-bit ripple-carry adder.
- Accepts a stream of WIDTH-bit operands over a valid/ready handshake and adds or subtracts each one into a running accumulator.
- After COUNT operands it presents the batch result with sticky unsigned-carry and signed-overflow flags, then waits for the consumer before starting the next batch.
- On the board it sits between switch/key input logic and the LEDR/HEX display drivers.

Parameters:
- WIDTH, 4, operand and accumulator width in bits (>=2)
- COUNT, 4, operands per batch (>=2); internal counter width is clog2(COUNT)

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  synchronous, active-low reset
- in_valid  input  1  in_data/sub are valid this cycle
- in_ready  output  1  block can accept an operand this cycle
- in_data  input  WIDTH  operand
- sub  input  1  1 = subtract in_data, 0 = add; sampled only on accept
- out_valid  output  1  batch result is valid
- out_ready  input  1  consumer takes the result this cycle
- out_sum  output  WIDTH  accumulator value; meaningful only while out_valid=1
- out_carry  output  1  sticky unsigned carry/borrow for the batch
- out_ovf  output  1  sticky signed (two's-complement) overflow for the batch

Behaviour:
Decided interface facts:
- One clock; reset is synchronous and active-low.
- Clock port is clk; reset port is reset_n.

Reset:
- reset_n=0 at a rising edge sets: state=ACCUM, acc=0, cnt=0, out_carry=0, out_ovf=0, out_valid=0.
- in_ready reads 1 in the first cycle after the reset edge.
- A reset mid-batch discards all partial results; nothing is emitted.

States:
- ACCUM: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
- in_ready and out_valid decode from registered state only. There is no combinational path from in_valid or out_ready.

Accept rule:
- An operand is accepted when in_valid=1 and in_ready=1 at a rising edge.
- Idle cycles (in_valid=0) change nothing.

Arithmetic on each accept:
- Effective operand: e = in_data if sub=0; e = ~in_data with carry-in 1 if sub=1.
- Sum: {c, r} = acc + e + cin, where cin=sub. Result is WIDTH+1 bits wide; acc <= r (mod 2^WIDTH).
- Carry flag: add sets out_carry if c=1. Subtract sets out_carry if c=0 (borrow).
- Overflow flag: out_ovf is set if acc[MSB]==e[MSB] and r[MSB]!=acc[MSB].
- Both flags are sticky (OR) for the whole batch.
- cnt <= cnt+1.

Transitions:
- ACCUM -> HOLD on the accept where cnt==COUNT-1. out_valid=1 in the next cycle, so latency is 1 cycle from the last accept. cnt wraps to 0.
- HOLD -> ACCUM when out_ready=1 at an edge. Clears acc, out_carry and out_ovf. in_ready=1 in the next cycle.
- In HOLD, in_valid is ignored, and out_sum and the flags stay stable for as long as out_ready=0.
- out_ready while out_valid=0 is ignored.
- Accept and result handoff can never coincide, because in_ready and out_valid are mutually exclusive.

Wrap-around:
- acc wraps modulo 2^WIDTH with no saturation.
- The flags are the only record of a wrap.

Test Plan:
All scenarios use WIDTH=4, COUNT=4, with out_ready=1 unless stated.
1. Reset, then add 3,4,5,1 on consecutive cycles -> in the cycle after the 4th accept: out_valid=1, out_sum=0xD, out_carry=0, out_ovf=1 (7+5 overflows signed).
2. Add 9,9,0,0 -> out_sum=0x2, out_carry=1, out_ovf=1; next cycle out_valid=0 and in_ready=1.
3. Add 5, sub 2, add 0, add 0 -> out_sum=0x3, out_carry=0, out_ovf=0. Follow with sub 1 on an acc of 0 -> acc=0xF, carry (borrow)=1, ovf=0 at batch end.
4. Backpressure: complete a batch (sum 0x6), hold out_ready=0 for 5 cycles while pulsing in_valid -> out_valid stays 1, in_ready stays 0, sum stays 0x6, no accepts. Raise out_ready -> one cycle later out_valid=0 and in_ready=1, and the next batch starts from acc=0.
5. Gapped input: operands 1,2,3,4 with 0-3 idle cycles between them -> out_valid only after the 4th accept, out_sum=0xA.
6. Accept 7,7, then drive reset_n=0 for one edge -> acc=0, cnt=0, out_valid=0. Then add 1,1,1,1 -> out_sum=0x4 with both flags 0.

Source files
------------

// File: rtl/add_accum.sv
// ============================================================================
// add_accum : batched add/subtract accumulator with sticky carry/overflow
// Revision  : 1.0
// ============================================================================
`default_nettype none

module add_accum #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH-1:0]   w_eff;
    logic [WIDTH:0]     w_sum;

    // Subtraction is acc + ~in_data + 1; carry-out of 0 means a borrow occurred.
    assign w_eff = sub ? ~in_data : in_data;
    assign w_sum = {1'b0, acc_q} + {1'b0, w_eff} + {{WIDTH{1'b0}}, sub};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = w_sum[WIDTH-1:0];
                    carry_d = carry_q | (w_sum[WIDTH] ^ sub);
                    ovf_d   = ovf_q | ((acc_q[WIDTH-1] == w_eff[WIDTH-1]) &&
                                       (w_sum[WIDTH-1] != acc_q[WIDTH-1]));
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == HOLD);
    assign out_sum   = acc_q;
    assign out_carry = carry_q;
    assign out_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_add_accum.sv
// ============================================================================
// tb_add_accum : directed, table-driven self-checking bench for add_accum
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_add_accum;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_carry;
    logic       out_ovf;

    int n_cmp;
    int n_fail;

    add_accum #(.WIDTH(4), .COUNT(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One batch: four operands, sub bit i pairs with data nibble i.
    typedef struct {
        logic [3:0]  subs;
        logic [15:0] data;
        logic [3:0]  exp_sum;
        logic        exp_c;
        logic        exp_o;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic s, input logic [3:0] d);
        @(negedge clk);
        check("in_ready_before_accept", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b1;
        sub      = s;
        in_data  = d;
    endtask

    task automatic run_batch(input logic [3:0] subs, input logic [15:0] data,
                             input logic [3:0] es, input logic ec, input logic eo);
        for (int i = 0; i < 4; i++) send(subs[i], data[i*4 +: 4]);
        @(negedge clk);
        in_valid = 1'b0;
        check("out_valid", {7'd0, out_valid}, 8'd1);
        check("in_ready_hold", {7'd0, in_ready}, 8'd0);
        check("out_sum", {4'd0, out_sum}, {4'd0, es});
        check("out_carry", {7'd0, out_carry}, {7'd0, ec});
        check("out_ovf", {7'd0, out_ovf}, {7'd0, eo});
        if (out_ready) begin
            @(negedge clk);
            check("out_valid_after_take", {7'd0, out_valid}, 8'd0);
            check("in_ready_after_take", {7'd0, in_ready}, 8'd1);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        sub       = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{subs: 4'b0000, data: 16'h1543, exp_sum: 4'hD, exp_c: 1'b0, exp_o: 1'b1};
        vecs[1] = '{subs: 4'b0000, data: 16'h0099, exp_sum: 4'h2, exp_c: 1'b1, exp_o: 1'b1};
        vecs[2] = '{subs: 4'b0010, data: 16'h0025, exp_sum: 4'h3, exp_c: 1'b0, exp_o: 1'b0};
        vecs[3] = '{subs: 4'b0001, data: 16'h0001, exp_sum: 4'hF, exp_c: 1'b1, exp_o: 1'b0};
        vecs[4] = '{subs: 4'b0001, data: 16'h0008, exp_sum: 4'h8, exp_c: 1'b1, exp_o: 1'b1};
        vecs[5] = '{subs: 4'b0000, data: 16'h001F, exp_sum: 4'h0, exp_c: 1'b1, exp_o: 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_in_ready", {7'd0, in_ready}, 8'd1);
        check("reset_out_valid", {7'd0, out_valid}, 8'd0);
        check("reset_sum", {4'd0, out_sum}, 8'd0);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++)
            run_batch(vecs[v].subs, vecs[v].data, vecs[v].exp_sum, vecs[v].exp_c, vecs[v].exp_o);

        // Backpressure: result must hold while consumer stalls, input ignored.
        out_ready = 1'b0;
        run_batch(4'b0000, 16'h0321, 4'h6, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid;
            in_data  = 4'h7;
            @(negedge clk);
            check("bp_out_valid", {7'd0, out_valid}, 8'd1);
            check("bp_in_ready", {7'd0, in_ready}, 8'd0);
            check("bp_sum", {4'd0, out_sum}, 8'h06);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", {7'd0, out_valid}, 8'd0);
        check("bp_release_ready", {7'd0, in_ready}, 8'd1);
        check("bp_release_acc", {4'd0, out_sum}, 8'd0);
        run_batch(4'b0000, 16'h1111, 4'h4, 1'b0, 1'b0);

        // Gapped input: result only after the fourth accept.
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 4'(i + 1));
            @(negedge clk);
            in_valid = 1'b0;
            if (i < 3) begin
                check("gap_no_valid", {7'd0, out_valid}, 8'd0);
                repeat (i) begin
                    @(negedge clk);
                    check("gap_idle_no_valid", {7'd0, out_valid}, 8'd0);
                end
            end
        end
        check("gap_valid", {7'd0, out_valid}, 8'd1);
        check("gap_sum", {4'd0, out_sum}, 8'h0A);
        check("gap_carry", {7'd0, out_carry}, 8'd0);
        check("gap_ovf", {7'd0, out_ovf}, 8'd1);
        @(negedge clk);
        check("gap_taken", {7'd0, out_valid}, 8'd0);

        // Reset mid-batch discards partial state.
        send(1'b0, 4'h7);
        send(1'b0, 4'h7);
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_acc", {4'd0, out_sum}, 8'h0E);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_reset_valid", {7'd0, out_valid}, 8'd0);
        check("mid_reset_ready", {7'd0, in_ready}, 8'd1);
        check("mid_reset_acc", {4'd0, out_sum}, 8'd0);
        run_batch(4'b0000, 16'h1111, 4'h4, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
